// File: rtl/bus_drive_sched_pkg.sv
// bus_sched_pkg: state encoding shared by the bus drive scheduler
package bus_sched_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, PRECHARGE} bus_sched_state_t;
endpackage

// File: rtl/bus_drive_sched_if.sv
// bus_drive_sched_if: requester handshake, lane enables and resolved bus value
interface bus_drive_sched_if #(parameter int N = 4, parameter int W = 8);
  logic [N-1:0] req;
  logic [N-1:0] req_and;
  logic [W-1:0] bus_in;
  logic [N-1:0] gnt;
  logic [N-1:0] driver_enable;
  logic [N-1:0] ack;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  modport master (output req, req_and, bus_in, input gnt, driver_enable, ack, rd_data, rd_valid);
  modport slave  (input req, req_and, bus_in, output gnt, driver_enable, ack, rd_data, rd_valid);
endinterface

// File: rtl/bus_drive_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after rr_ptr
module rr_arbiter #(parameter int N = 4) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         winner,
  output logic [$clog2(N)-1:0] winner_idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] w_j;
  // scanning from the far end lets the nearest request overwrite the rest
  always_comb begin
    winner = '0;
    winner_idx = '0;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(rr_ptr) + k) % N);
      if (req[w_j]) begin
        winner = '0;
        winner[w_j] = 1'b1;
        winner_idx = w_j;
      end
    end
  end
endmodule

// File: rtl/bus_drive_sched.sv
// bus_drive_sched: grants open-drain bus drive rights, precharges between transfers
// and returns the resolved bus value with a completion pulse.
module bus_drive_sched import bus_sched_pkg::*; #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int HOLD = 1
) (
  input logic clk,
  input logic rst_n,
  bus_drive_sched_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(HOLD + 1);
  bus_sched_state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [IW-1:0] r_ptr, w_ptr_n, r_win, w_win_n, w_ptr, w_idx;
  logic [N-1:0]  r_gnt, w_gnt, r_ack, w_ack, w_win, w_gnt_new;
  logic [W-1:0]  r_rd, w_rd;
  logic          r_rv, w_rv, w_last;
  // the pointer moves past the finished winner before the precharge arbitration
  assign w_ptr = r_state == PRECHARGE ? (r_win == IW'(N - 1) ? '0 : r_win + IW'(1)) : r_ptr;
  rr_arbiter #(.N(N)) u_arb (.req(bus.req), .rr_ptr(w_ptr), .winner(w_win), .winner_idx(w_idx));
  assign w_gnt_new = bus.req_and[w_idx] ? (w_win | (bus.req & bus.req_and)) : w_win;
  assign w_last = r_cnt == CW'(HOLD - 1);
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_ptr_n = r_ptr;
    w_win_n = r_win;
    w_gnt = r_gnt;
    w_ack = '0;
    w_rd = r_rd;
    w_rv = 1'b0;
    case (r_state)
      IDLE, PRECHARGE: begin
        w_ptr_n = w_ptr;
        w_win_n = w_idx;
        w_cnt = '0;
        w_gnt = |bus.req ? w_gnt_new : '0;
        w_state = |bus.req ? DRIVE : IDLE;
      end
      DRIVE: begin
        w_cnt = w_last ? r_cnt : r_cnt + CW'(1);
        w_state = w_last ? PRECHARGE : DRIVE;
        w_gnt = w_last ? '0 : r_gnt;
        w_ack = w_last ? r_gnt : '0;
        w_rv = w_last;
        w_rd = w_last ? bus.bus_in : r_rd;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_ptr <= '0;
      r_win <= '0;
      r_gnt <= '0;
      r_ack <= '0;
      r_rd <= '0;
      r_rv <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_ptr <= w_ptr_n;
      r_win <= w_win_n;
      r_gnt <= w_gnt;
      r_ack <= w_ack;
      r_rd <= w_rd;
      r_rv <= w_rv;
    end
  end
  assign bus.gnt = r_gnt;
  assign bus.driver_enable = r_gnt;
  assign bus.ack = r_ack;
  assign bus.rd_data = r_rd;
  assign bus.rd_valid = r_rv;
endmodule

// File: tb/tb_bus_drive_sched.sv
// tb_bus_drive_sched: HOLD=1 and HOLD=3 schedulers against a transaction-level model
module tb_bus_drive_sched;
  localparam int N = 4;
  localparam int W = 8;
  typedef struct {logic [N-1:0] g; logic [W-1:0] d; int cyc;} txn_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0, req_and = '0;
  logic [W-1:0] vals [N];
  logic [N-1:0] en_a [2], gnt_a [2], ack_a [2];
  logic [W-1:0] rd_a [2];
  logic rv_a [2];
  int n_chk = 0, n_err = 0, cyc = 0;
  bit rst_prev = 1'b1;
  int dleft [2], mptr [2], mwin [2];
  logic [N-1:0] mg [2];
  txn_t q [2][$];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 2; k++) begin : g_dut
    bus_drive_sched_if #(.N(N), .W(W)) bi ();
    logic [W-1:0] b;
    // open-drain lanes: released drivers float high, enabled ones pull low
    always_comb begin
      b = '1;
      for (int i = 0; i < N; i++) if (bi.driver_enable[i]) b &= vals[i];
    end
    assign bi.req = req;
    assign bi.req_and = req_and;
    assign bi.bus_in = b;
    assign en_a[k] = bi.driver_enable;
    assign gnt_a[k] = bi.gnt;
    assign ack_a[k] = bi.ack;
    assign rd_a[k] = bi.rd_data;
    assign rv_a[k] = bi.rd_valid;
    bus_drive_sched #(.N(N), .W(W), .HOLD(k == 0 ? 1 : 3)) dut (.clk(clk), .rst_n(rst_n), .bus(bi));
  end
  function automatic int hold_of(input int k);
    return k == 0 ? 1 : 3;
  endfunction
  function automatic void arb(input logic [N-1:0] r, ra, input int p, output int w, output logic [N-1:0] g);
    w = -1;
    for (int s = 0; s < N; s++) if (w < 0 && r[(p + s) % N]) w = (p + s) % N;
    g = N'(1) << w;
    if (ra[w]) g |= r & ra;
  endfunction
  function automatic logic [W-1:0] wired_and(input logic [N-1:0] g);
    logic [W-1:0] d = '1;
    for (int i = 0; i < N; i++) if (g[i]) d &= vals[i];
    return d;
  endfunction
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s hold=%0d cycle=%0d: got %0h expected %0h", nm, hold_of(k), cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      logic [N-1:0] e;
      txn_t t;
      e = dleft[k] > 0 ? mg[k] : '0;
      chk("driver_enable", k, 32'(en_a[k]), 32'(e));
      chk("gnt", k, 32'(gnt_a[k]), 32'(e));
      if (rst_prev) chk("rd_data_reset", k, 32'(rd_a[k]), 0);
      if (ack_a[k] != '0 || rv_a[k]) begin
        if (q[k].size() == 0) chk("unexpected_ack", k, {27'd0, rv_a[k], ack_a[k]}, 0);
        else begin
          t = q[k].pop_front();
          chk("ack", k, 32'(ack_a[k]), 32'(t.g));
          chk("rd_valid", k, 32'(rv_a[k]), 1);
          chk("rd_data", k, 32'(rd_a[k]), 32'(t.d));
          chk("ack_cycle", k, cyc, t.cyc);
        end
      end else if (q[k].size() != 0 && q[k][0].cyc <= cyc) begin
        t = q[k].pop_front();
        chk("ack", k, 32'(ack_a[k]), 32'(t.g));
      end
      if (!rst_n) begin
        dleft[k] = 0;
        mptr[k] = 0;
        q[k].delete();
      end else if (dleft[k] > 0) begin
        dleft[k]--;
        if (dleft[k] == 0) begin
          q[k].push_back('{g: mg[k], d: wired_and(mg[k]), cyc: cyc + 1});
          mptr[k] = (mwin[k] + 1) % N;
        end
      end else if (req != '0) begin
        arb(req, req_and, mptr[k], mwin[k], mg[k]);
        dleft[k] = hold_of(k);
      end
    end
    rst_prev = !rst_n;
  end
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] ra, input int n);
    req = r;
    req_and = ra;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < N; i++) vals[i] = W'($urandom);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive('0, '0, 10);
    vals[0] = 8'h5A;
    drive(4'b0001, '0, 4);
    drive('0, '0, 6);
    drive(4'b1111, '0, 20);
    drive('0, '0, 6);
    drive(4'b0001, '0, 2);
    drive('0, '0, 5);
    vals[1] = 8'hF0;
    vals[2] = 8'h3C;
    drive(4'b0110, 4'b0110, 3);
    drive('0, '0, 6);
    drive(4'b0001, '0, 1);
    drive('0, '0, 1);
    rst_n = 1'b0;
    drive('0, '0, 1);
    rst_n = 1'b1;
    drive(4'b1111, '0, 8);
    drive('0, '0, 6);
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) vals[$urandom_range(0, N - 1)] = W'($urandom);
      rst_n = $urandom_range(0, 199) != 0;
      drive(N'($urandom & $urandom), N'($urandom), 1);
    end
    rst_n = 1'b1;
    drive('0, '0, 12);
    for (int k = 0; k < 2; k++) chk("pending_ack", k, q[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bus_drive_sched.md
# bus_drive_sched

Sequencing and arbitration controller for an internal open-drain bus built from `bus_bit` lanes. It grants drive rights to one requester at a time, or to a cooperating group for wired-AND transfers, and generates the per-requester `driver_enable` vector for every lane. Between transfers it inserts a precharge cycle with all drivers released, so the bus floats high. It samples the resolved bus value and returns it with a completion pulse. It sits between the CPU core's internal bus sources (registers, ALU, data latch) and the `bus_bit` lane array.

## Interface
- `N`, default 4: number of requesters; must be ≥ 2.
- `W`, default 8: bus width in lanes.
- `HOLD`, default 1: drive cycles per transfer; must be ≥ 1.

Ports:
- `clk` in, 1: single system clock.
- `rst_n` in, 1: reset, synchronous, active-low.
- `req` in, N: requester i wants a transfer. Sampled only at arbitration.
- `req_and` in, N: requester i accepts wired-AND co-drive.
- `bus_in` in, W: resolved value from the `bus_bit` lane outputs (combinational).
- `gnt` out, N: requesters owning the current transfer.
- `driver_enable` out, N: common enable to all W lanes. Equals `gnt` during DRIVE, otherwise 0.
- `ack` out, N: one-cycle pulse to every requester whose transfer just completed.
- `rd_data` out, W: bus value sampled on the last DRIVE cycle.
- `rd_valid` out, 1: one-cycle pulse, coincident with `ack`.

## Operation
- Three states, in a package enum: IDLE, DRIVE, PRECHARGE.
- **IDLE:** `driver_enable`=0 and `gnt`=0. If `|req`, arbitrate, load `gnt`, and go to DRIVE. Otherwise stay.
- **Arbitration:** round-robin starting at pointer `rr_ptr`. The winner is the first i at or after `rr_ptr` (cyclic) with `req[i]`.
  - If `req_and[winner]`=1, `gnt` = winner plus every j with `req[j] & req_and[j]`.
  - Otherwise `gnt` is one-hot on the winner.
- **DRIVE:** `driver_enable`=`gnt`. The hold counter counts from 0 up to HOLD-1. On the last count, register `rd_data`←`bus_in` and go to PRECHARGE.
- **PRECHARGE:** `driver_enable`=0 and `gnt`=0. `ack`=previous `gnt`; `rd_valid`=1. Set `rr_ptr` ← (winner+1) mod N. Co-granted requesters do not move the pointer.
  - In the same cycle, arbitrate using the updated pointer. If `|req`, load the new `gnt` and go to DRIVE; otherwise go to IDLE.
- If `req` drops during DRIVE, the transfer still completes and is acked.
- A requester must keep `req` high until its `ack` pulse. A `req` still high in the `ack` cycle counts as a new request.
- The empty bus (no drivers enabled) reads all-ones. The controller never asserts `driver_enable` outside DRIVE.
- Wired-AND: `rd_data` = AND of the co-drivers' values, as resolved by the lanes. No contention checking.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `rr_ptr`=0, `gnt`=0, `driver_enable`=0, `ack`=0, `rd_data`=0, `rd_valid`=0, hold counter 0.
- `rst_n` low in any state, including mid-DRIVE, forces reset values at the next edge. No `ack` is issued for an aborted transfer.
- Latency:
  - `req` high in IDLE at cycle t: `gnt` and `driver_enable` asserted in cycles t+1 … t+HOLD.
  - `ack`, `rd_valid` and the precharge (enables 0) occur in cycle t+HOLD+1.
- Back-to-back throughput: one transfer per HOLD+1 cycles. The next grant appears at t+HOLD+2.
- Every transfer is separated by at least one all-released cycle.
- `rr_ptr` update and re-arbitration in PRECHARGE happen in the same cycle. The newly updated pointer governs that arbitration.

## Structure
- Package `bus_sched_pkg`: state enum `bus_sched_state_t` {IDLE, DRIVE, PRECHARGE}.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req`, `rr_ptr`.
  - Outputs: one-hot `winner` and `winner_idx` (`$clog2(N)` bits).
  - Purely combinational.
- `bus_drive_sched` holds the FSM, hold counter (`$clog2(HOLD+1)` bits), `rr_ptr`, the co-grant mask, and the output registers.

## Test plan
- **Single requester:** N=4, W=8, HOLD=1; `req`=0001, requester 0 drives 0x5A. Expect:
  - `driver_enable`=0001 in cycle 1.
  - `ack`=0001, `rd_valid`=1, `rd_data`=0x5A in cycle 2; enables 0 in cycle 2.
- **Round robin:** `req`=1111 held continuously, `req_and`=0. Expect grants 0001, 0010, 0100, 1000, 0001 on every other cycle, with an all-zero enable cycle between each.
- **Wired-AND:** `req`=0110, `req_and`=0110, values 0xF0 and 0x3C, `rr_ptr`=1.
  - Expect `gnt`=0110 and `rd_data`=0x30.
  - Expect `ack`=0110 and next `rr_ptr`=2.
- **HOLD=3:** single request. Expect enable high for exactly 3 cycles and `ack` in cycle 4. Dropping `req` in cycle 2 does not shorten the transfer.
- **Reset mid-DRIVE:** HOLD=3, `rst_n` low in cycle 2. Expect all outputs 0 next cycle, no `ack`, and `rr_ptr`=0 (the next `req`=1111 grants 0001).
- **Idle bus:** `req`=0 for 10 cycles. Expect `driver_enable`=0, `ack`=0, `rd_valid`=0 throughout.
